// File: rtl/bounce_square_ctrl.sv
// bounce_square_ctrl
//   Sequencer for the bouncing-square animation feeding vga_adapter.
//   go (from IDLE) clears the whole screen and draws the square. After that,
//   every frame tick erases the square, moves it one pixel diagonally with
//   wall bounce, and redraws it. At most one pixel write is issued per clock.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low
//   go          level; leaves IDLE (ignored elsewhere)
//   pause       level; holds the sequencer in WAIT_FRAME
//   colour_in   square colour, latched when entering DRAW
//   x_out/y_out pixel coordinate (registered)
//   colour_out  pixel colour (registered)
//   plot        write strobe, aligned with x/y/colour (registered)
//   busy        high whenever the sequencer is not IDLE (registered)
module bounce_square_ctrl #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int SIZE      = 4,
  parameter int FRAME_DIV = 833333,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       pause,
  input  logic [2:0] colour_in,
  output logic [8:0] x_out,
  output logic [7:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy
);

  localparam int LS = $clog2(SIZE);
  localparam int PW = 2 * LS;
  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [8:0]    X_MAX  = 9'(SCREEN_W - SIZE);
  localparam logic [7:0]    Y_MAX  = 8'(SCREEN_H - SIZE);
  localparam logic [XW-1:0] CX_END = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] CY_END = YW'(SCREEN_H - 1);
  localparam logic [DW-1:0] DIV_LD = DW'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_ERASE, S_MOVE, S_DRAW
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] cx, cx_n;
  logic [YW-1:0] cy, cy_n;
  logic [PW-1:0] pix, pix_n;
  logic [8:0]    px, px_n;
  logic [7:0]    py, py_n;
  logic          dx_r, dx_n;   // 1 = moving right
  logic          dy_d, dy_n;   // 1 = moving down
  logic [2:0]    col_q, col_n;
  logic [DW-1:0] div;
  logic          tick, tick_pending, consume;

  // Registered-output staging values
  logic [8:0] ox;
  logic [7:0] oy;
  logic [2:0] ocol;
  logic       oplot;

  // Square pixel offsets: column is the low half of the pixel counter so
  // the scan runs across a row before stepping down.
  logic [LS-1:0] pc, pr;
  assign pc = pix[LS-1:0];
  assign pr = pix[PW-1:LS];

  assign tick = (div == '0);

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    pix_n   = pix;
    px_n    = px;
    py_n    = py;
    dx_n    = dx_r;
    dy_n    = dy_d;
    col_n   = col_q;
    consume = 1'b0;
    ox      = '0;
    oy      = '0;
    ocol    = '0;
    oplot   = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_CLEAR;
          cx_n    = '0;
          cy_n    = '0;
        end
      end
      S_CLEAR: begin
        oplot = 1'b1;
        ox    = 9'(cx);
        oy    = 8'(cy);
        if (cx == CX_END) begin
          cx_n = '0;
          if (cy == CY_END) begin
            state_n = S_DRAW;
            pix_n   = '0;
            col_n   = colour_in;
          end else begin
            cy_n = cy + YW'(1);
          end
        end else begin
          cx_n = cx + XW'(1);
        end
      end
      S_WAIT: begin
        if (tick_pending && !pause) begin
          state_n = S_ERASE;
          pix_n   = '0;
          consume = 1'b1;
        end
      end
      S_ERASE: begin
        oplot = 1'b1;
        ox    = px + 9'(pc);
        oy    = py + 8'(pr);
        pix_n = pix + PW'(1);
        if (pix == '1) state_n = S_MOVE;
      end
      S_MOVE: begin
        col_n   = colour_in;
        state_n = S_DRAW;
        pix_n   = '0;
        // Bounce turns around in place: the flip cycle already steps back
        // inward, so the square never sits outside the legal range.
        if (dx_r) begin
          if (px == X_MAX) begin dx_n = 1'b0; px_n = px - 9'd1; end
          else                  px_n = px + 9'd1;
        end else begin
          if (px == '0) begin dx_n = 1'b1; px_n = 9'd1; end
          else               px_n = px - 9'd1;
        end
        if (dy_d) begin
          if (py == Y_MAX) begin dy_n = 1'b0; py_n = py - 8'd1; end
          else                  py_n = py + 8'd1;
        end else begin
          if (py == '0) begin dy_n = 1'b1; py_n = 8'd1; end
          else               py_n = py - 8'd1;
        end
      end
      S_DRAW: begin
        oplot = 1'b1;
        ox    = px + 9'(pc);
        oy    = py + 8'(pr);
        ocol  = col_q;
        pix_n = pix + PW'(1);
        if (pix == '1) state_n = S_WAIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cx           <= '0;
      cy           <= '0;
      pix          <= '0;
      px           <= 9'(X0);
      py           <= 8'(Y0);
      dx_r         <= 1'b1;
      dy_d         <= 1'b1;
      col_q        <= '0;
      div          <= '0;
      tick_pending <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      colour_out   <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= state_n;
      cx    <= cx_n;
      cy    <= cy_n;
      pix   <= pix_n;
      px    <= px_n;
      py    <= py_n;
      dx_r  <= dx_n;
      dy_d  <= dy_n;
      col_q <= col_n;
      div   <= tick ? DIV_LD : div - DW'(1);
      // A tick landing in the consuming cycle is a new frame and stays pending.
      tick_pending <= tick | (tick_pending & ~consume);
      x_out      <= ox;
      y_out      <= oy;
      colour_out <= ocol;
      plot       <= oplot;
      busy       <= (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bounce_square_ctrl.sv
// Bench for bounce_square_ctrl at 16x12, SIZE 4, FRAME_DIV 50.
module tb_bounce_square_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, pause;
  logic [2:0] colour_in;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy;

  bounce_square_ctrl #(
    .SCREEN_W(16), .SCREEN_H(12), .SIZE(4), .FRAME_DIV(50), .X0(0), .Y0(0)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { logic [2:0] col; int ex; int ey; } frame_t;

  pix_t exp_q[$];
  int   pc_q[$];
  int   n_pass = 0, n_total = 0;
  int   npop = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Cycles since reset release; ticks set tick_pending at cyc%50==1.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard: every plot pops one expected pixel.
  always @(negedge clk) begin
    if (plot) begin
      pix_t e;
      pc_q.push_back(cyc);
      npop++;
      if (exp_q.size() == 0) chk("stray_plot", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pix_x", int'(x_out), e.x);
        chk("pix_y", int'(y_out), e.y);
        chk("pix_col", int'(colour_out), e.c);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic push_clear();
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 16; x++) exp_q.push_back('{x, y, 0});
  endtask

  task automatic push_sq(input int ox, input int oy, input int c);
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) exp_q.push_back('{ox + cc, oy + r, c});
  endtask

  task automatic wait_empty(input string name, input int budget);
    int b = budget;
    while (exp_q.size() != 0 && b > 0) begin step(); b--; end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_y"}, int'(y_out), 0);
    chk({tag, "_col"}, int'(colour_out), 0);
  endtask

  initial begin
    // Expected square origin after each move, starting at (0,0) right+down.
    // Covers bottom bounce (move 9), right bounce (13), top bounce (17)
    // and the bottom-left corner (25).
    frame_t tbl[26] = '{
      '{3'd1, 1, 1},  '{3'd2, 2, 2},  '{3'd3, 3, 3},  '{3'd4, 4, 4},
      '{3'd5, 5, 5},  '{3'd6, 6, 6},  '{3'd7, 7, 7},  '{3'd1, 8, 8},
      '{3'd2, 9, 7},  '{3'd3, 10, 6}, '{3'd4, 11, 5}, '{3'd5, 12, 4},
      '{3'd6, 11, 3}, '{3'd7, 10, 2}, '{3'd1, 9, 1},  '{3'd2, 8, 0},
      '{3'd3, 7, 1},  '{3'd4, 6, 2},  '{3'd5, 5, 3},  '{3'd6, 4, 4},
      '{3'd7, 3, 5},  '{3'd1, 2, 6},  '{3'd2, 1, 7},  '{3'd3, 0, 8},
      '{3'd4, 1, 7},  '{3'd5, 2, 6}
    };
    int ox = 0, oy = 0;
    int n0, b;

    reset = 1'b0; go = 1'b0; pause = 1'b0; colour_in = 3'b100;
    repeat (3) @(posedge clk);
    step();
    check_idle_outputs("reset");

    // Out of reset with go low: stays idle.
    reset = 1'b1;
    repeat (3) step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_plot", int'(plot), 0);

    // Start: full clear then first draw at origin with colour 100.
    push_clear();
    push_sq(0, 0, 4);
    go = 1'b1;
    repeat (3) step();
    chk("start_busy", int'(busy), 1);
    wait_empty("clear_draw_done", 400);

    for (int k = 0; k < 26; k++) begin
      if (k == 4) begin
        // Held across three ticks: nothing may be plotted.
        pause = 1'b1;
        n0 = npop;
        repeat (150) step();
        chk("pause_noplot", npop, n0);
        chk("pause_busy", int'(busy), 1);
        b = 60;
        while ((cyc % 50) != 2 && b > 0) begin step(); b--; end
        chk("pause_phase_found", int'(b > 0), 1);
      end
      colour_in = tbl[k].col;
      pc_q.delete();
      push_sq(ox, oy, 0);
      push_sq(tbl[k].ex, tbl[k].ey, int'(tbl[k].col));
      pause = 1'b0;
      wait_empty("frame_done", 200);
      // 16 erase, one MOVE gap, 16 draw: first to last spans 32 cycles.
      if (pc_q.size() == 32) chk("frame_span", pc_q[31] - pc_q[0], 32);
      else                   chk("frame_plots", pc_q.size(), 32);
      if (k == 4) begin
        // Collapsed ticks give exactly one frame; next tick is later.
        n0 = npop;
        repeat (10) step();
        chk("after_pause_single", npop, n0);
      end
      ox = tbl[k].ex;
      oy = tbl[k].ey;
    end

    // Reset in the middle of DRAW (draw pixel index 5).
    colour_in = 3'd6;
    push_sq(ox, oy, 0);
    push_sq(3, 5, 6);
    n0 = npop;
    b = 200;
    while (npop < n0 + 22 && b > 0) begin step(); b--; end
    chk("reach_draw_px5", npop - n0, 22);
    reset = 1'b0;
    step();
    check_idle_outputs("abort");
    exp_q.delete();
    step();
    chk("abort_hold_plot", int'(plot), 0);

    // go still high: restart from a full clear with the square back at (0,0).
    colour_in = 3'd2;
    push_clear();
    push_sq(0, 0, 2);
    reset = 1'b1;
    wait_empty("restart_done", 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
